// File: rtl/percept_bus_pkg.sv
// percept_bus_pkg: frame constants and state encoding shared by the bus arbiter and percept_if nodes
package percept_bus_pkg;
  typedef enum logic [2:0] {IDLE, START, ADDR, DATA, GAP} bus_state_t;
  localparam int FRAME_ADDR_BITS = 8;
  localparam int FRAME_DATA_BITS = 8;
  localparam logic SERIAL_IDLE = 1'b1;
  localparam logic SERIAL_START = 1'b0;
endpackage

// File: rtl/percept_rr_arb.sv
// percept_rr_arb: combinational round-robin pick starting after the last granted requester
module percept_rr_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  input  logic               first,
  output logic               valid,
  output logic [2:0]         idx,
  output logic [NUM_REQ-1:0] oh
);
  int base, j;
  // nobody served since reset: search from 0, otherwise from the slot after the last grant
  always_comb begin
    base = first ? 0 : (int'(ptr) + 1) % NUM_REQ;
    valid = 1'b0;
    idx = '0;
    oh = '0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (base + k) % NUM_REQ;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx = 3'(j);
        oh[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/percept_bus_arb.sv
// percept_bus_arb: round-robin arbiter serialising (addr, data) frames onto the shared perceptron bus
module percept_bus_arb
  import percept_bus_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_BITS   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   addr_in,
  input  logic [8*NUM_REQ-1:0]   data_in,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             done_id,
  output logic                   serial_out
);
  bus_state_t state, state_n;
  logic [7:0] timer, addr_q, data_q;
  logic [3:0] cnt, cnt_n;
  logic [2:0] ptr, idx_q, pick_idx;
  logic first, pick_valid, bit_end;
  logic [NUM_REQ-1:0] pick_oh;
  percept_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr (
    .req(req),
    .ptr(ptr),
    .first(first),
    .valid(pick_valid),
    .idx(pick_idx),
    .oh(pick_oh)
  );
  assign busy = state != IDLE;
  assign done_id = idx_q;
  assign serial_out = state == START ? SERIAL_START :
                      state == ADDR  ? addr_q[cnt[2:0]] :
                      state == DATA  ? data_q[cnt[2:0]] : SERIAL_IDLE;
  // frame sequencing: advance one bit position each time the bit timer wraps
  always_comb begin
    bit_end = timer == 8'(BIT_CYCLES - 1);
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE:  state_n = pick_valid ? START : IDLE;
      START: if (bit_end) begin
        state_n = ADDR;
        cnt_n = '0;
      end
      ADDR:  if (bit_end) begin
        state_n = cnt == 4'(FRAME_ADDR_BITS - 1) ? DATA : ADDR;
        cnt_n = cnt == 4'(FRAME_ADDR_BITS - 1) ? '0 : cnt + 4'd1;
      end
      DATA:  if (bit_end) begin
        state_n = cnt == 4'(FRAME_DATA_BITS - 1) ? GAP : DATA;
        cnt_n = cnt == 4'(FRAME_DATA_BITS - 1) ? '0 : cnt + 4'd1;
      end
      GAP:   if (bit_end) begin
        state_n = cnt == 4'(GAP_BITS - 1) ? IDLE : GAP;
        cnt_n = cnt == 4'(GAP_BITS - 1) ? '0 : cnt + 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, timers, request latch and one-cycle gnt/done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      cnt <= '0;
      ptr <= '0;
      first <= 1'b1;
      addr_q <= '0;
      data_q <= '0;
      idx_q <= '0;
      gnt <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      timer <= (state == IDLE || bit_end) ? '0 : timer + 8'd1;
      gnt <= state == IDLE ? pick_oh : '0;
      done <= state == DATA && state_n == GAP;
      if (state == IDLE && pick_valid) begin
        addr_q <= addr_in[8*pick_idx +: 8];
        data_q <= data_in[8*pick_idx +: 8];
        idx_q <= pick_idx;
        ptr <= pick_idx;
        first <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_percept_bus_arb.sv
// tb_percept_bus_arb: directed checks of framing, timing, round-robin order and reset for percept_bus_arb
module tb_percept_bus_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req = '0, req3 = '0;
  logic [15:0] addr_in = '0, data_in = '0, addr3 = '0, data3 = '0;
  logic [1:0] gnt, gnt3;
  logic busy, done, serial_out, busy3, done3, ser3;
  logic [2:0] done_id, done_id3;
  logic [18:0] f3;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  percept_bus_arb #(.NUM_REQ(2), .BIT_CYCLES(1), .GAP_BITS(2)) dut (
    .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .data_in(data_in),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .serial_out(serial_out)
  );
  percept_bus_arb #(.NUM_REQ(2), .BIT_CYCLES(3), .GAP_BITS(2)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .addr_in(addr3), .data_in(data3),
    .gnt(gnt3), .busy(busy3), .done(done3), .done_id(done_id3), .serial_out(ser3)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // called in the gnt cycle; leaves the bench in the first IDLE cycle after the frame
  task automatic frame1(input logic [1:0] eg, input logic [7:0] a, input logic [7:0] d,
                        input logic [2:0] eid, input bit clobber);
    logic [18:0] f;
    f = {2'b11, d, a, 1'b0};
    for (int i = 0; i < 19; i++) begin
      chk("gnt", 32'(gnt), i == 0 ? 32'(eg) : 32'd0);
      chk("busy", 32'(busy), 32'd1);
      chk("serial", 32'(serial_out), 32'(f[i]));
      chk("done", 32'(done), 32'(i == 17));
      if (i == 17) chk("done_id", 32'(done_id), 32'(eid));
      tick(1);
      if (clobber && i == 0) addr_in[7:0] = 8'h00;
    end
    chk("busy_end", 32'(busy), 32'd0);
    chk("serial_idle", 32'(serial_out), 32'd1);
  endtask
  initial begin
    tick(1);
    chk("rst_serial", 32'(serial_out), 32'd1);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("idle_busy", 32'(busy), 32'd0);
    req = 2'b01; addr_in = 16'h0002; data_in = 16'h00A5;
    tick(1);
    req = 2'b00;
    frame1(2'b01, 8'h02, 8'hA5, 3'd0, 1'b0);
    tick(1);
    chk("stay_idle", 32'(busy), 32'd0);
    req3 = 2'b01; addr3 = 16'h0001; data3 = 16'h0080;
    tick(1);
    req3 = 2'b00;
    chk("gnt3", 32'(gnt3), 32'd1);
    f3 = {2'b11, 8'h80, 8'h01, 1'b0};
    for (int i = 0; i < 57; i++) begin
      chk("serial3", 32'(ser3), 32'(f3[i/3]));
      chk("busy3", 32'(busy3), 32'd1);
      chk("done3", 32'(done3), 32'(i == 51));
      tick(1);
    end
    chk("busy3_end", 32'(busy3), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req = 2'b11; addr_in = 16'h2211; data_in = 16'hBBAA;
    tick(1);
    frame1(2'b01, 8'h11, 8'hAA, 3'd0, 1'b0);
    tick(1);
    frame1(2'b10, 8'h22, 8'hBB, 3'd1, 1'b0);
    tick(1);
    frame1(2'b01, 8'h11, 8'hAA, 3'd0, 1'b0);
    req = 2'b00;
    tick(1);
    chk("rr_idle", 32'(busy), 32'd0);
    req = 2'b01; addr_in = 16'h0003; data_in = 16'h005A;
    tick(1);
    req = 2'b00;
    frame1(2'b01, 8'h03, 8'h5A, 3'd0, 1'b1);
    req = 2'b01; addr_in = 16'h770F; data_in = 16'h66F0;
    tick(1);
    req = 2'b10;
    chk("pre_rst_gnt", 32'(gnt), 32'd1);
    tick(13);
    chk("data_bit4", 32'(serial_out), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_serial", 32'(serial_out), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_done_id", 32'(done_id), 32'd0);
    tick(1);
    req = 2'b00;
    frame1(2'b10, 8'h77, 8'h66, 3'd1, 1'b0);
    req = 2'b01; addr_in = 16'h4C3C; data_in = 16'h5DC3;
    tick(1);
    req = 2'b10;
    frame1(2'b01, 8'h3C, 8'hC3, 3'd0, 1'b0);
    chk("pending_no_gnt", 32'(gnt), 32'd0);
    tick(1);
    req = 2'b00;
    frame1(2'b10, 8'h4C, 8'h5D, 3'd1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/percept_bus_arb.md
Name: percept_bus_arb

Overview:
- Arbitrates a single serial perceptron bus among NUM_REQ requesters (e.g. UART command path, training sequencer).
- Accepts one (address, data) request at a time and serialises it as a frame onto the bus line shared by all percept_if nodes.
- Inserts a guaranteed idle gap between frames.
- Replaces ad-hoc single-source bit shifting at the perceptron top level.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- BIT_CYCLES, 1, clock cycles each serial bit is held (1..255).
- GAP_BITS, 2, idle-high bit periods after each frame (1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; level, held until granted.
- addr_in  in  8*NUM_REQ  requester i target address in bits [8i+7:8i].
- data_in  in  8*NUM_REQ  requester i payload in bits [8i+7:8i].
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: request i accepted.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when frame bits are complete.
- done_id  out  3  index of requester whose frame completed; valid with done.
- serial_out  out  1  bus line; idle high.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, serial_out=1, gnt=0, busy=0, done=0, done_id=0, rr pointer=0, bit timer and bit counter=0.
- Reset mid-frame: same values at the next edge. The frame is truncated and not retried.
- Frame format: start bit 0; addr[0..7] LSB first; data[0..7] LSB first; GAP_BITS ones. Each bit is held exactly BIT_CYCLES cycles.
- States: IDLE -> START -> ADDR -> DATA -> GAP -> IDLE.
- IDLE:
  - serial_out=1.
  - At an edge with |req, a round-robin pick latches addr, data and index.
  - Registered outputs take effect next cycle: state=START, serial_out=0, gnt[idx]=1 for that one cycle, busy=1.
- START: after BIT_CYCLES cycles -> ADDR, bit counter=0.
- ADDR: serial_out=addr[cnt]; cnt advances every BIT_CYCLES cycles; after bit 7 -> DATA, cnt=0.
- DATA: same as ADDR using data; after bit 7 -> GAP.
- GAP:
  - serial_out=1.
  - done=1 and done_id=idx on the first GAP cycle only.
  - After GAP_BITS*BIT_CYCLES cycles -> IDLE.
- Timing:
  - Frame occupancy is (17+GAP_BITS)*BIT_CYCLES cycles from the gnt cycle to the first IDLE cycle.
  - A new request sampled in the first IDLE cycle starts the next frame with no extra bubble.
  - Minimum spacing between start bits is (17+GAP_BITS)*BIT_CYCLES+1 cycles.
- Round-robin:
  - Priority order starts at (last_granted+1) mod NUM_REQ, then wraps.
  - After a grant, the pointer is set to the granted index.
  - Simultaneous requests are granted in cyclic order; no requester waits more than NUM_REQ-1 frames.
- Requester rule:
  - Hold req, addr and data stable until gnt is seen.
  - Drop req in the gnt cycle; a req still high after gnt is treated as a new request.
  - Addr and data are latched at acceptance, so later changes do not affect the frame in flight.
- Requests are ignored (not queued) while busy; req stays pending.
- Requests with index >= NUM_REQ do not exist. done_id upper bits are zero.
- Bit timer counts 0..BIT_CYCLES-1 and wraps. With BIT_CYCLES=1 every cycle is a new bit.

Decomposition:
- Package percept_bus_pkg:
  - state encoding constants (IDLE, START, ADDR, DATA, GAP);
  - FRAME_ADDR_BITS=8, FRAME_DATA_BITS=8;
  - SERIAL_IDLE=1, SERIAL_START=0.
  - Shared with percept_if.
- Sub-module percept_rr_arb:
  - combinational one-hot round-robin pick from req plus pointer;
  - outputs a valid flag and index.
- The pointer register lives in percept_bus_arb.

Test Plan:
- Single request, BIT_CYCLES=1, GAP_BITS=2, req0 with addr=0x02, data=0xA5:
  - gnt[0] pulses one cycle after req is sampled.
  - serial_out sequence: 0 | 0,1,0,0,0,0,0,0 | 1,0,1,0,0,1,0,1 | 1,1.
  - done=1 and done_id=0 on the first gap cycle; busy low after 19 cycles.
- BIT_CYCLES=3, addr=0x01, data=0x80: every bit lasts 3 cycles; total busy is 57 cycles; serial matches the expanded pattern.
- req0 and req1 high together, both held, three frames:
  - grant order 0,1,0 from reset;
  - each frame carries its own addr/data;
  - start bits are 20 cycles apart (BIT_CYCLES=1, GAP_BITS=2).
- Requester changes addr_in from 0x03 to 0x00 in the cycle after gnt: the frame still carries 0x03.
- rst asserted during the DATA bit 4 cycle:
  - next cycle serial_out=1, busy=0, gnt=0, done=0, pointer=0;
  - a pending req1 is granted after rst is released.
- req1 asserted while a req0 frame is in flight: no gnt during busy; gnt[1] one cycle after the first IDLE cycle.
